// File: rtl/sobel_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 Sobel window datapath: counts pixels, strobes the line buffer, emits windows.
// Optional SOBEL_SCAN_BORDER_EN: every pixel emits a window and border_o tags the partial ones.
module sobel_scan_ctrl #(
    parameter int WIDTH_P = 11,
    parameter int IMG_W_P = 640,
    parameter int IMG_H_P = 480
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               lb_we_o,
    output logic               win_valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] win_col_o,
    output logic [WIDTH_P-1:0] win_row_o,
    output logic               eol_o,
    output logic               eof_o,
    output logic               busy_o,
    output logic               frame_done_o
`ifdef SOBEL_SCAN_BORDER_EN
    ,
    output logic               border_o
`endif
);

    localparam logic [WIDTH_P-1:0] LAST_COL = WIDTH_P'(IMG_W_P - 1);
    localparam logic [WIDTH_P-1:0] LAST_ROW = WIDTH_P'(IMG_H_P - 1);
    localparam logic [WIDTH_P-1:0] ONE      = WIDTH_P'(1);
    localparam logic [WIDTH_P-1:0] TWO      = WIDTH_P'(2);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH_P-1:0] col;
    logic [WIDTH_P-1:0] row;
    logic               accept;
    logic               emit;
    logic               at_eol;
    logic               is_border;

    // A held window blocks new pixels unless it is being taken this cycle.
    assign ready_o   = ((state == PRIME) || (state == ACTIVE)) && (!win_valid_o || ready_i);
    assign accept    = valid_i && ready_o;
    assign lb_we_o   = accept;
    assign at_eol    = (col == LAST_COL);
    assign is_border = (col < TWO) || (row < TWO);
    assign busy_o    = (state != IDLE);

`ifdef SOBEL_SCAN_BORDER_EN
    assign emit = accept;
`else
    assign emit = accept && !is_border;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            win_valid_o  <= 1'b0;
            win_col_o    <= '0;
            win_row_o    <= '0;
            eol_o        <= 1'b0;
            eof_o        <= 1'b0;
            frame_done_o <= 1'b0;
`ifdef SOBEL_SCAN_BORDER_EN
            border_o     <= 1'b0;
`endif
        end else begin
            frame_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    col <= '0;
                    row <= '0;
                    if (start_i) state <= PRIME;
                end
                PRIME: begin
                    if (accept && at_eol && (row == ONE)) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (accept && at_eol && (row == LAST_ROW)) state <= DRAIN;
                end
                DRAIN: begin
                    // The eof window is always pending here; finish once it is taken.
                    if (win_valid_o && ready_i) begin
                        state        <= DONE;
                        frame_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (accept) begin
                if (at_eol) begin
                    col <= '0;
                    row <= row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end

            // A new window overwrites one being taken, keeping back-to-back throughput.
            if (emit) begin
                win_valid_o <= 1'b1;
                win_col_o   <= col;
                win_row_o   <= row;
                eol_o       <= at_eol;
                eof_o       <= at_eol && (row == LAST_ROW);
`ifdef SOBEL_SCAN_BORDER_EN
                border_o    <= is_border;
`endif
            end else if (ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Randomised self-checking bench for sobel_scan_ctrl against a frame-level pixel/window reference model.
// Honours SOBEL_SCAN_BORDER_EN the same way as the design.
module tb_sobel_scan_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int WD = 4;
`ifdef SOBEL_SCAN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          start;
    logic          valid;
    logic          ready_in;
    logic          ready_o;
    logic          lb_we_o;
    logic          win_valid_o;
    logic [WD-1:0] win_col_o;
    logic [WD-1:0] win_row_o;
    logic          eol_o;
    logic          eof_o;
    logic          busy_o;
    logic          frame_done_o;
`ifdef SOBEL_SCAN_BORDER_EN
    logic          border_o;
`endif

    sobel_scan_ctrl #(
        .WIDTH_P(WD),
        .IMG_W_P(W),
        .IMG_H_P(H)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .valid_i     (valid),
        .ready_o     (ready_o),
        .lb_we_o     (lb_we_o),
        .win_valid_o (win_valid_o),
        .ready_i     (ready_in),
        .win_col_o   (win_col_o),
        .win_row_o   (win_row_o),
        .eol_o       (eol_o),
        .eof_o       (eof_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o)
`ifdef SOBEL_SCAN_BORDER_EN
        ,
        .border_o    (border_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: frame in progress, pixels accepted so far, and the pending window.
    bit m_active;
    bit m_done;
    bit m_pend;
    int m_n;
    int m_col;
    int m_row;
    bit m_eol;
    bit m_eof;
    bit m_border;

    int dut_windows;
    int dut_borders;
    int dut_dones;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_active = 0;
        m_done   = 0;
        m_pend   = 0;
        m_n      = 0;
        m_col    = 0;
        m_row    = 0;
        m_eol    = 0;
        m_eof    = 0;
        m_border = 0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rstn     = 1'b0;
        start    = 1'b0;
        valid    = 1'b0;
        ready_in = 1'b0;
        #1;
        checkOutput("rst_ready", ready_o, 0);
        checkOutput("rst_lb_we", lb_we_o, 0);
        checkOutput("rst_win_valid", win_valid_o, 0);
        checkOutput("rst_win_col", win_col_o, 0);
        checkOutput("rst_win_row", win_row_o, 0);
        checkOutput("rst_eol", eol_o, 0);
        checkOutput("rst_eof", eof_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_frame_done", frame_done_o, 0);
`ifdef SOBEL_SCAN_BORDER_EN
        checkOutput("rst_border", border_o, 0);
`endif
        modelReset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Drive one cycle, compare outputs with the model, then advance the model past the next edge.
    task automatic applyStimulus(input bit s, input bit v, input bit r);
        bit exp_ready;
        bit take;
        bit acc;
        bit nd;
        bit was_idle;
        int c;
        int rr;
        @(negedge clk);
        start    = s;
        valid    = v;
        ready_in = r;
        #1;
        exp_ready = m_active && (m_n < W * H) && (!m_pend || r);
        checkOutput("ready", ready_o, exp_ready);
        checkOutput("lb_we", lb_we_o, v && exp_ready);
        checkOutput("win_valid", win_valid_o, m_pend);
        checkOutput("busy", busy_o, m_active || m_done);
        checkOutput("frame_done", frame_done_o, m_done);
        if (m_pend) begin
            checkOutput("win_col", win_col_o, m_col);
            checkOutput("win_row", win_row_o, m_row);
            checkOutput("eol", eol_o, m_eol);
            checkOutput("eof", eof_o, m_eof);
`ifdef SOBEL_SCAN_BORDER_EN
            checkOutput("border", border_o, m_border);
`endif
        end

        if (win_valid_o === 1'b1 && r) begin
            dut_windows++;
`ifdef SOBEL_SCAN_BORDER_EN
            if (border_o === 1'b1) dut_borders++;
`endif
        end
        if (frame_done_o === 1'b1) dut_dones++;

        was_idle = !m_active && !m_done;
        take     = m_pend && r;
        acc      = v && exp_ready;
        nd       = take && m_eof;
        if (nd) m_active = 0;
        if (acc) begin
            c  = m_n % W;
            rr = m_n / W;
            m_n++;
            if (BORDER || (c >= 2 && rr >= 2)) begin
                m_pend   = 1;
                m_col    = c;
                m_row    = rr;
                m_eol    = (c == W - 1);
                m_eof    = (c == W - 1) && (rr == H - 1);
                m_border = (c < 2) || (rr < 2);
            end else if (take) begin
                m_pend = 0;
            end
        end else if (take) begin
            m_pend = 0;
        end
        if (was_idle && s) begin
            m_active = 1;
            m_n      = 0;
        end
        m_done = nd;
    endtask

    // mode 0: continuous, 1: 5-cycle stall at window (4,3), 2: gapped source, 3: random
    task automatic runFrame(input int mode);
        int hold;
        bit s;
        bit v;
        bit r;
        hold        = 0;
        dut_windows = 0;
        dut_borders = 0;
        dut_dones   = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 2000 && (m_active || m_done); cyc++) begin
            s = 0;
            v = 1;
            r = 1;
            case (mode)
                1: if (m_pend && m_col == 4 && m_row == 3 && hold < 5) begin
                    r = 0;
                    hold++;
                end
                2: v = (cyc % 2 == 0);
                3: begin
                    v = 1'($urandom_range(0, 1));
                    r = 1'($urandom_range(0, 1));
                    s = ($urandom_range(0, 3) == 0);
                end
                default: ;
            endcase
            applyStimulus(s, v, r);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("frame_windows", dut_windows, BORDER ? W * H : (W - 2) * (H - 2));
        checkOutput("frame_done_pulses", dut_dones, 1);
`ifdef SOBEL_SCAN_BORDER_EN
        checkOutput("frame_border_windows", dut_borders, W * H - (W - 2) * (H - 2));
`endif
    endtask

    initial begin
        rstn     = 1'b1;
        start    = 1'b0;
        valid    = 1'b0;
        ready_in = 1'b0;
        modelReset();
        applyReset();

        // valid in IDLE must not be accepted or counted
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);

        runFrame(0);
        runFrame(1);
        runFrame(2);

        // reset mid-frame, then restart from (0,0)
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b1);
        applyReset();
        dut_dones = 0;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("no_done_after_reset", dut_dones, 0);
        runFrame(0);

        repeat (3) runFrame(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
